// File: rtl/tail_input_cond.sv
// Input conditioning for the tail-light sequencer: sync, debounce, mode encode, step tick.
// Define DEBOUNCE_BYPASS_EN to skip the debounce counters (outputs follow the synchronisers).
module tail_input_cond #(
  parameter int unsigned TICK_DIV   = 5000000,
  parameter int unsigned DEB_CYCLES = 100000
) (
  input  logic       ADC_CLK_10,
  input  logic       KEY0,
  input  logic [2:0] sw_raw,
  input  logic       key1_raw,
  output logic       hazard,
  output logic       turn_en,
  output logic       brake,
  output logic       dir_left,
  output logic [1:0] mode,
  output logic       mode_chg,
  output logic       tick
);

  localparam int unsigned NumIn = 4;
  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_LEFT   = 2'd1,
    MODE_RIGHT  = 2'd2,
    MODE_HAZARD = 2'd3
  } modeE;

  logic [NumIn-1:0] rawVec;
  logic [NumIn-1:0] syncQ1;
  logic [NumIn-1:0] syncQ2;
  logic [NumIn-1:0] stableVec;
  modeE             modeNext;
  modeE             modeQ;
  logic             restart;
  logic             modeChgQ;
  logic [TickW-1:0] tickCnt;
  logic             tickQ;

  // Bit order: [0] hazard, [1] turn enable, [2] brake, [3] direction
  assign rawVec = {key1_raw, sw_raw};

  // Two-flop synchronisers
  always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
    if (!KEY0) begin
      syncQ1 <= '0;
      syncQ2 <= '0;
    end else begin
      syncQ1 <= rawVec;
      syncQ2 <= syncQ1;
    end
  end

`ifdef DEBOUNCE_BYPASS_EN
  assign stableVec = syncQ2;
`else
  localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);

  // A disagreement must persist DEB_CYCLES edges; any return to the stable value restarts it
  for (genvar i = 0; i < NumIn; i++) begin : gDeb
    logic [DebW-1:0] debCnt;
    logic            stableQ;

    always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
      if (!KEY0) begin
        debCnt  <= '0;
        stableQ <= 1'b0;
      end else if (syncQ2[i] == stableQ) begin
        debCnt <= '0;
      end else if (debCnt == DebW'(DEB_CYCLES - 1)) begin
        stableQ <= syncQ2[i];
        debCnt  <= '0;
      end else begin
        debCnt <= debCnt + DebW'(1);
      end
    end

    assign stableVec[i] = stableQ;
  end
`endif

  assign hazard   = stableVec[0];
  assign turn_en  = stableVec[1];
  assign brake    = stableVec[2];
  assign dir_left = stableVec[3];

  // Mode priority: hazard, then turn (direction chosen by KEY[1]), else idle
  always_comb begin
    modeNext = MODE_IDLE;
    if (stableVec[0]) begin
      modeNext = MODE_HAZARD;
    end else if (stableVec[1]) begin
      modeNext = stableVec[3] ? MODE_LEFT : MODE_RIGHT;
    end
  end

  assign restart = (modeNext != modeQ);

  always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
    if (!KEY0) begin
      modeQ    <= MODE_IDLE;
      modeChgQ <= 1'b0;
    end else begin
      modeQ    <= modeNext;
      modeChgQ <= restart;
    end
  end

  // Step tick; a mode change restarts the cadence and wins over a coincident wrap
  always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
    if (!KEY0) begin
      tickCnt <= '0;
      tickQ   <= 1'b0;
    end else if (restart) begin
      tickCnt <= '0;
      tickQ   <= 1'b0;
    end else if (tickCnt == TickW'(TICK_DIV - 1)) begin
      tickCnt <= '0;
      tickQ   <= 1'b1;
    end else begin
      tickCnt <= tickCnt + TickW'(1);
      tickQ   <= 1'b0;
    end
  end

  assign mode     = modeQ;
  assign mode_chg = modeChgQ;
  assign tick     = tickQ;

endmodule

// File: tb/tb_tail_input_cond.sv
// Bench for tail_input_cond: window-based reference model checked every cycle plus literal timing pins.
// Honours DEBOUNCE_BYPASS_EN so the same bench covers both builds.
module tb_tail_input_cond;

  localparam int TickDiv   = 8;
  localparam int DebCycles = 4;
`ifdef DEBOUNCE_BYPASS_EN
  localparam int Lat    = 2;
  localparam bit Bypass = 1'b1;
`else
  localparam int Lat    = DebCycles + 2;
  localparam bit Bypass = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [2:0] swRaw = 3'b000;
  logic       key1Raw = 1'b0;
  logic       hazard, turnEn, brake, dirLeft, modeChg, tick;
  logic [1:0] mode;
  logic [8:0] dutVec;

  int compared = 0;
  int mismatched = 0;

  // Reference model state (edge count since reset release, sampled raw history)
  int         n = 0;
  int         lastRestart = 0;
  logic [3:0] rawH [0:2047];
  logic [3:0] expOut = '0;
  logic [1:0] expMode = '0;
  logic       expChg = 1'b0;
  logic       expTick = 1'b0;

  tail_input_cond #(.TICK_DIV(TickDiv), .DEB_CYCLES(DebCycles)) dut (
    .ADC_CLK_10(clk),
    .KEY0      (rstN),
    .sw_raw    (swRaw),
    .key1_raw  (key1Raw),
    .hazard    (hazard),
    .turn_en   (turnEn),
    .brake     (brake),
    .dir_left  (dirLeft),
    .mode      (mode),
    .mode_chg  (modeChg),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  assign dutVec = {dirLeft, brake, turnEn, hazard, mode, modeChg, tick};

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic syncSeen(input int i, input int k);
    if (k < 3 || k - 2 > 2047) return 1'b0;
    return rawH[k-2][i];
  endfunction

  // Model: output flips once the last DebCycles synchronised samples all disagree with it
  task automatic modelLoop();
    forever begin
      @(posedge clk);
      if (!rstN) begin
        n = 0; lastRestart = 0; expOut = '0; expMode = '0; expChg = 1'b0; expTick = 1'b0;
      end else begin
        logic [3:0] prevOut;
        logic [1:0] m;
        bit allFlip;
        n++;
        if (n <= 2047) rawH[n] = {key1Raw, swRaw};
        prevOut = expOut;
        for (int i = 0; i < 4; i++) begin
          if (Bypass) begin
            expOut[i] = (n >= 2) ? rawH[n-1][i] : 1'b0;
          end else begin
            allFlip = 1'b1;
            for (int k = n - DebCycles + 1; k <= n; k++)
              if (syncSeen(i, k) == expOut[i]) allFlip = 1'b0;
            if (allFlip) expOut[i] = ~expOut[i];
          end
        end
        m = prevOut[0] ? 2'd3 : (prevOut[1] ? (prevOut[3] ? 2'd1 : 2'd2) : 2'd0);
        expChg  = (m != expMode);
        expMode = m;
        if (expChg) lastRestart = n;
        expTick = !expChg && (((n - lastRestart) % TickDiv) == 0);
      end
      #1;
      check("cycle", dutVec, {expOut, expMode, expChg, expTick});
    end
  endtask

  task automatic edges(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  initial begin
    fork
      modelLoop();
    join_none

    // Reset with every input high
    swRaw = 3'b111; key1Raw = 1'b1;
    edges(3);
    check("reset_outputs", dutVec, 9'd0);
    @(negedge clk); rstN = 1'b1; swRaw = 3'b000; key1Raw = 1'b0;
    edges(7);  check("no_tick_at_7", 9'(tick), 9'd0);
    edges(1);  check("first_tick_at_8", 9'(tick), 9'd1);
    edges(1);  check("tick_one_cycle", 9'(tick), 9'd0);
    edges(7);  check("second_tick_at_16", 9'(tick), 9'd1);

    // Hazard: debounce latency, mode update, restart of tick cadence
    @(negedge clk); swRaw = 3'b001;
    edges(Lat - 1); check("hazard_not_yet", 9'(hazard), 9'd0);
    edges(1);       check("hazard_rise", {7'd0, hazard, mode == 2'd0}, 9'd3);
    edges(1);       check("mode_hazard", {6'd0, mode, modeChg}, 9'b111);
    edges(1);       check("chg_single", 9'(modeChg), 9'd0);
    edges(6);       check("no_tick_restart_7", 9'(tick), 9'd0);
    edges(1);       check("tick_restart_8", 9'(tick), 9'd1);

    // Turn: right then left
    @(negedge clk); swRaw = 3'b000;
    edges(12); check("back_idle", 9'(mode), 9'd0);
    @(negedge clk); swRaw = 3'b010; key1Raw = 1'b0;
    edges(Lat + 1); check("mode_right", {6'd0, mode, modeChg}, 9'b101);
    edges(4);
    @(negedge clk); key1Raw = 1'b1;
    edges(Lat + 1); check("mode_left", {6'd0, mode, modeChg}, 9'b011);

    // Short glitches on KEY[1]
    @(negedge clk); swRaw = 3'b000; key1Raw = 1'b0;
    edges(12); check("idle_dir_right", {7'd0, dirLeft, mode == 2'd0}, 9'd1);
    @(negedge clk); key1Raw = 1'b1;
    edges(3);
    @(negedge clk); key1Raw = 1'b0;
    edges(12);
`ifndef DEBOUNCE_BYPASS_EN
    check("glitch3_blocked", {6'd0, dirLeft, mode}, 9'd0);
    @(negedge clk); key1Raw = 1'b1;
    edges(4);
    @(negedge clk); key1Raw = 1'b0;
    edges(Lat - 4); check("pulse4_passes", 9'(dirLeft), 9'd1);
`endif
    edges(12);

    // Brake only, then a short hazard glitch on top of it
    @(negedge clk); swRaw = 3'b100;
    edges(Lat);  check("brake_rise", {7'd0, brake, mode == 2'd0}, 9'd3);
    edges(3);    check("brake_no_chg", {6'd0, mode, modeChg}, 9'd0);
    @(negedge clk); swRaw = 3'b101;
    edges(2);
    @(negedge clk); swRaw = 3'b100;
    edges(12);

    // Turn enable and direction qualify together: one update
    @(negedge clk); swRaw = 3'b010; key1Raw = 1'b1;
    edges(Lat + 1); check("simul_left", {6'd0, mode, modeChg}, 9'b011);
    edges(1);       check("simul_one_pulse", 9'(modeChg), 9'd0);
    edges(5);

    // Asynchronous reset mid-count
    @(posedge clk); #3; rstN = 1'b0;
    #1; check("async_reset", dutVec, 9'd0);
    edges(2);
    @(negedge clk); rstN = 1'b1; swRaw = 3'b001; key1Raw = 1'b0;
    edges(Lat + 1); check("after_reset_hazard", {6'd0, mode, modeChg}, 9'b111);
    edges(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tail_input_cond.md
Name: tail_input_cond

Overview:
- Upstream stage of the tail-light sequencer. Conditions the raw DE10-Lite switches and KEY[1] before the sequencer uses them.
- Synchronises and debounces every control input, then encodes a registered lighting mode.
- Generates the step tick that paces the sequencer's LED pattern.
- Issues a one-cycle restart pulse whenever the mode changes, so the sequencer always begins a new pattern from its first step.

Parameters:
- TICK_DIV, 5000000, ADC_CLK_10 cycles per step tick (10 MHz gives a 2 Hz step); legal range >= 1.
- DEB_CYCLES, 100000, consecutive stable synchronised cycles required before an input is accepted (10 ms); legal range >= 1.

Ports:
- ADC_CLK_10  input  1  system clock, 10 MHz.
- KEY0  input  1  reset, driven from KEY[0]. Asynchronous, active-low.
- sw_raw  input  3  raw switches: [0] hazard, [1] turn enable, [2] brake.
- key1_raw  input  1  raw KEY[1] direction: 1 = left, 0 = right.
- hazard  output  1  debounced sw_raw[0].
- turn_en  output  1  debounced sw_raw[1].
- brake  output  1  debounced sw_raw[2].
- dir_left  output  1  debounced key1_raw.
- mode  output  2  registered mode: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD.
- mode_chg  output  1  one-cycle pulse, asserted in the cycle after mode takes a new value.
- tick  output  1  one-cycle step pulse.

Behaviour:
- Reset (KEY0 = 0): immediate asynchronous clear of all synchroniser flops, stable flops, counters and outputs to 0. This gives mode = IDLE, dir_left = 0, tick = 0, mode_chg = 0.
- Reset asserted mid-operation aborts any debounce in progress and any partial tick count.
- After KEY0 rises, the first tick comes TICK_DIV edges later.

Synchroniser:
- Each of the 4 inputs passes through a 2-flop synchroniser. The synchronised value is valid 2 edges after the raw input changes.

Debounce (one instance per input):
- Each instance holds a stable flop and a counter of width $clog2(DEB_CYCLES+1).
- If the synchronised value equals stable, the counter is cleared.
- Otherwise the counter increments. When it reaches DEB_CYCLES-1 on an edge, stable takes the synchronised value and the counter is cleared.
- A steady raw change therefore appears on its output DEB_CYCLES+2 edges after first sampling.
- Any glitch shorter than DEB_CYCLES cycles never propagates, because a return to the old value clears the counter.

Mode encoder (registered, 1 edge after the stable values):
- hazard = 1 -> HAZARD, overriding everything else.
- else turn_en = 1 -> LEFT if dir_left, otherwise RIGHT.
- else -> IDLE.
- brake does not affect mode; it is passed through to the sequencer separately.

Mode change:
- mode_chg = 1 for exactly the one cycle after mode is updated to a value different from its previous value.
- A register write of the same value produces no pulse.

Tick counter:
- Width $clog2(TICK_DIV). Counts 0 to TICK_DIV-1.
- tick = 1 in the cycle following the edge on which the counter wraps from TICK_DIV-1 to 0.
- With TICK_DIV = 1, tick is held at 1 continuously after reset.

Simultaneous events:
- A mode change clears the tick counter to 0 and suppresses any tick due on that same edge, so the restart takes priority over the tick.
- After a restart, the next tick comes exactly TICK_DIV edges later.

Independence of inputs:
- Inputs debounce independently. Changes to different inputs complete on whatever edges their own counters allow.
- Several inputs qualifying on the same edge produce a single mode update and at most one mode_chg pulse.

Optional Feature:
- Macro: DEBOUNCE_BYPASS_EN.
- Defined: the debounce counters are not built. Each output equals its synchroniser output directly, so a raw change reaches the output 2 edges after sampling. This is used by short simulations (around 32 clocks).
- Undefined: full debounce as described in Behaviour.
- The mode, mode_chg and tick logic is identical in both builds.

Test Plan (DEB_CYCLES = 4, TICK_DIV = 8, macro undefined unless noted):
1. Hold KEY0 = 0 for 3 cycles with all inputs high -> every output is 0; releasing KEY0 gives the first tick 8 edges later, then a tick every 8 cycles.
2. KEY0 high; sw_raw = 3'b001 held -> hazard rises 6 edges after first sampling; mode = 3 one edge later; mode_chg pulses once; the tick counter restarts, giving the next tick 8 edges after the restart.
3. sw_raw[1] = 1 with key1_raw = 0, then key1_raw = 1 held steady -> mode goes 0 -> 2 -> 1, with one mode_chg pulse for each transition.
4. Pulse key1_raw high for 3 cycles (shorter than DEB_CYCLES) -> dir_left stays 0, no mode_chg, tick cadence unchanged.
5. sw_raw = 3'b100 (brake only) -> brake = 1 after 6 edges; mode stays 0; no mode_chg.
6. DEBOUNCE_BYPASS_EN defined; sw_raw[0] set -> hazard = 1 after 2 edges, mode = 3 on the 3rd edge. Then assert KEY0 = 0 mid-count -> all outputs 0 immediately, without waiting for a clock edge.
